multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RISC-V datapath.
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback cycles.
- Drives all datapath enables and mux selects, and produces the 2-bit ALUOp consumed by the ALU decoder stage directly downstream.
- Supports lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
- none (encodings fixed by datapath)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- op  input  7  instruction opcode field, from instruction register
- Zero  input  1  ALU zero flag
- ImmSrc  output  2  immediate format select: 00 I, 01 S, 10 B, 11 J
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- AdrSrc  output  1  memory address: 0 PC, 1 Result
- ALUOp  output  2  to ALU decoder: 00 add, 01 subtract, 10 funct-decoded
- IRWrite  output  1  instruction register enable
- PCWrite  output  1  PC enable
- RegWrite  output  1  register file write enable
- MemWrite  output  1  data memory write enable
- Illegal  output  1  illegal-opcode flag (see Optional Feature)

Behaviour:
- Reset: asynchronous, active-high. State forced to FETCH immediately, including mid-instruction; outputs take FETCH values while reset is held.
- Outputs are Moore-decoded from state only. Exceptions:
  - PCWrite = PCUpdate | (Branch & Zero).
  - ImmSrc is combinational from op: lw/I-type 00, sw 01, beq 10, jal 11, all others 00.
- Unlisted output defaults in every state: selects 00, enables 0.
- Per-state outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other -> see Optional Feature.
  - MEMADR: op=0000011 -> MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB->FETCH.
  - MEMWRITE->FETCH.
  - EXECUTER/EXECUTEI/JAL -> ALUWB -> FETCH.
  - BEQ->FETCH.
- Cycle counts, FETCH through the last state inclusive: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- Zero is sampled only in BEQ. Zero toggling in any other state has no effect on PCWrite.
- op must be stable from DECODE until the instruction completes; it is driven by the IR, which only loads in FETCH.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> TRAP state.
  - TRAP: all enables 0, Illegal=1, self-loop until reset.
- Undefined:
  - Unknown opcode in DECODE -> FETCH (instruction acts as NOP; PC already advanced).
  - Illegal tied to 0; TRAP state does not exist.

Test Plan:
- Reset pulse mid-MEMREAD of lw -> state FETCH within the same cycle; IRWrite=1, PCWrite=1, ALUSrcB=10, RegWrite=0 while reset is high.
- lw (op=0000011) -> exactly 5 cycles; RegWrite=1 only in cycle 5 with ResultSrc=01; AdrSrc=1 in cycle 4; next cycle IRWrite=1.
- sw (op=0100011) -> MemWrite=1 only in cycle 4; RegWrite never 1; ImmSrc=01 throughout.
- add (op=0110011) -> ALUOp=10 and ALUSrcB=00 in cycle 3; RegWrite=1 in cycle 4. addi (op=0010011) -> same, with ALUSrcB=01.
- beq (op=1100011), 3 cycles:
  - Zero=1 in cycle 3 -> PCWrite=1, ALUOp=01.
  - Repeat with Zero=0 -> PCWrite=0.
  - Zero=1 held during DECODE of a non-branch instruction -> PCWrite=0.
- op=1111111:
  - Macro defined -> Illegal=1 from cycle 3 onward, no writes for 10 cycles, recovers on reset.
  - Macro undefined -> FETCH in cycle 3, Illegal=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RISC-V datapath (lw, sw, R/I-type ALU, beq, jal).
// Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in a TRAP state; otherwise they act as NOPs.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [1:0] ALUOp,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Illegal
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBeq,
    StJal
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    StTrap
`endif
  } state_e;

  state_e state_q, state_d;
  logic   pc_update;
  logic   branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        unique case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
`ifdef MC_ILLEGAL_TRAP_EN
          default:         state_d = StTrap;
`else
          default:         state_d = StFetch;
`endif
        endcase
      end
      StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StJal:      state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
`ifdef MC_ILLEGAL_TRAP_EN
      StTrap:     state_d = StTrap;
`endif
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    ALUOp     = 2'b00;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    unique case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      StDecode: begin
        // Precompute the branch target while the opcode is decoded.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      StExecuteR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      StExecuteI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      StAluWb: RegWrite = 1'b1;
      StBeq: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      StJal: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite = pc_update | (branch & Zero);

  always_comb begin
    unique case (op)
      OpStore: ImmSrc = 2'b01;
      OpBeq:   ImmSrc = 2'b10;
      OpJal:   ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  assign Illegal = (state_q == StTrap);
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; outputs are sampled mid-cycle,
// 1 time unit after the falling edge.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       Zero;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal;

  int compared = 0;
  int mismatched = 0;

  multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .Zero      (Zero),
    .ImmSrc    (ImmSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .AdrSrc    (AdrSrc),
    .ALUOp     (ALUOp),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .Illegal   (Illegal)
  );

  // {ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUOp, IRWrite, PCWrite, RegWrite, MemWrite, Illegal}
  logic [13:0] obs;
  assign obs = {ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUOp, IRWrite, PCWrite, RegWrite,
                MemWrite, Illegal};

  localparam logic [13:0] ExpFetch  = 14'b00_10_10_0_00_1_1_0_0_0;
  localparam logic [13:0] ExpDecode = 14'b01_01_00_0_00_0_0_0_0_0;
  localparam logic [13:0] ExpMemAdr = 14'b10_01_00_0_00_0_0_0_0_0;
  localparam logic [13:0] ExpMemRd  = 14'b00_00_00_1_00_0_0_0_0_0;
  localparam logic [13:0] ExpMemWb  = 14'b00_00_01_0_00_0_0_1_0_0;
  localparam logic [13:0] ExpMemWr  = 14'b00_00_00_1_00_0_0_0_1_0;
  localparam logic [13:0] ExpExeR   = 14'b10_00_00_0_10_0_0_0_0_0;
  localparam logic [13:0] ExpExeI   = 14'b10_01_00_0_10_0_0_0_0_0;
  localparam logic [13:0] ExpAluWb  = 14'b00_00_00_0_00_0_0_1_0_0;
  localparam logic [13:0] ExpBeqZ1  = 14'b10_00_00_0_01_0_1_0_0_0;
  localparam logic [13:0] ExpBeqZ0  = 14'b10_00_00_0_01_0_0_0_0_0;
  localparam logic [13:0] ExpJal    = 14'b01_10_00_0_00_0_1_0_0_0;
  localparam logic [13:0] ExpTrap   = 14'b00_00_00_0_00_0_0_0_0_1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b1;
    op    = 7'b0000000;
    Zero  = 1'b1;
    #1;
    compared++;
    if (obs !== ExpFetch) begin
      mismatched++;
      $display("FAIL reset_hold: got %b want %b", obs, ExpFetch);
    end
    @(negedge clk);
    #1;
    compared++;
    if (obs !== ExpFetch) begin
      mismatched++;
      $display("FAIL reset_after_edge: got %b want %b", obs, ExpFetch);
    end
    reset = 1'b0;
    Zero  = 1'b0;
  endtask

  task automatic test_lw();
    logic [13:0] want [5];
    want = '{ExpFetch, ExpDecode, ExpMemAdr, ExpMemRd, ExpMemWb};
    op = 7'b0000011;
    for (int c = 0; c < 5; c++) begin
      Zero = c[0];  // Zero must be ignored outside BEQ
      #1;
      compared++;
      if (obs !== want[c] || ImmSrc !== 2'b00) begin
        mismatched++;
        $display("FAIL lw_c%0d: got %b imm %b want %b imm 00", c + 1, obs, ImmSrc, want[c]);
      end
      @(negedge clk);
    end
    Zero = 1'b0;
  endtask

  task automatic test_sw();
    logic [13:0] want [4];
    want = '{ExpFetch, ExpDecode, ExpMemAdr, ExpMemWr};
    op = 7'b0100011;
    for (int c = 0; c < 4; c++) begin
      Zero = 1'b1;
      #1;
      compared++;
      if (obs !== want[c] || ImmSrc !== 2'b01) begin
        mismatched++;
        $display("FAIL sw_c%0d: got %b imm %b want %b imm 01", c + 1, obs, ImmSrc, want[c]);
      end
      @(negedge clk);
    end
    Zero = 1'b0;
  endtask

  task automatic test_alu(input logic [6:0] opcode, input logic [13:0] exec_exp);
    logic [13:0] want [4];
    want = '{ExpFetch, ExpDecode, exec_exp, ExpAluWb};
    op = opcode;
    for (int c = 0; c < 4; c++) begin
      Zero = 1'b1;
      #1;
      compared++;
      if (obs !== want[c] || ImmSrc !== 2'b00) begin
        mismatched++;
        $display("FAIL alu_%b_c%0d: got %b imm %b want %b imm 00", opcode, c + 1, obs, ImmSrc,
                 want[c]);
      end
      @(negedge clk);
    end
    Zero = 1'b0;
  endtask

  task automatic test_beq(input logic zero_in);
    logic [13:0] want [3];
    want = '{ExpFetch, ExpDecode, zero_in ? ExpBeqZ1 : ExpBeqZ0};
    op = 7'b1100011;
    for (int c = 0; c < 3; c++) begin
      Zero = (c == 2) ? zero_in : ~zero_in;
      #1;
      compared++;
      if (obs !== want[c] || ImmSrc !== 2'b10) begin
        mismatched++;
        $display("FAIL beq_z%0d_c%0d: got %b imm %b want %b imm 10", zero_in, c + 1, obs, ImmSrc,
                 want[c]);
      end
      @(negedge clk);
    end
    Zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [13:0] want [4];
    want = '{ExpFetch, ExpDecode, ExpJal, ExpAluWb};
    op = 7'b1101111;
    for (int c = 0; c < 4; c++) begin
      #1;
      compared++;
      if (obs !== want[c] || ImmSrc !== 2'b11) begin
        mismatched++;
        $display("FAIL jal_c%0d: got %b imm %b want %b imm 11", c + 1, obs, ImmSrc, want[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
`ifdef MC_ILLEGAL_TRAP_EN
    logic [13:0] want [12];
    want[0] = ExpFetch;
    want[1] = ExpDecode;
    for (int i = 2; i < 12; i++) want[i] = ExpTrap;
    op = 7'b1111111;
    for (int c = 0; c < 12; c++) begin
      Zero = 1'b1;
      #1;
      compared++;
      if (obs !== want[c]) begin
        mismatched++;
        $display("FAIL illegal_c%0d: got %b want %b", c + 1, obs, want[c]);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (obs !== ExpFetch) begin
      mismatched++;
      $display("FAIL trap_recover: got %b want %b", obs, ExpFetch);
    end
    @(negedge clk);
    reset = 1'b0;
    Zero  = 1'b0;
`else
    logic [13:0] want [4];
    want = '{ExpFetch, ExpDecode, ExpFetch, ExpDecode};
    op = 7'b1111111;
    for (int c = 0; c < 4; c++) begin
      Zero = 1'b1;
      #1;
      compared++;
      if (obs !== want[c] || ImmSrc !== 2'b00) begin
        mismatched++;
        $display("FAIL illegal_c%0d: got %b imm %b want %b imm 00", c + 1, obs, ImmSrc, want[c]);
      end
      @(negedge clk);
    end
    Zero = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_lw();
    logic [13:0] want [4];
    want = '{ExpFetch, ExpDecode, ExpMemAdr, ExpMemRd};
    op = 7'b0000011;
    for (int c = 0; c < 4; c++) begin
      #1;
      compared++;
      if (obs !== want[c]) begin
        mismatched++;
        $display("FAIL rst_lw_c%0d: got %b want %b", c + 1, obs, want[c]);
      end
      if (c < 3) @(negedge clk);
    end
    // Asynchronous reset in the middle of MEMREAD, away from any clock edge.
    #1 reset = 1'b1;
    #1;
    compared++;
    if (obs !== ExpFetch) begin
      mismatched++;
      $display("FAIL rst_async: got %b want %b", obs, ExpFetch);
    end
    @(negedge clk);
    #1;
    compared++;
    if (obs !== ExpFetch) begin
      mismatched++;
      $display("FAIL rst_held: got %b want %b", obs, ExpFetch);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    compared++;
    if (obs !== ExpDecode) begin
      mismatched++;
      $display("FAIL rst_resume: got %b want %b", obs, ExpDecode);
    end
    // Finish this lw so the next test starts from FETCH.
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [13:0] want [9];
    logic [6:0]  ops  [9];
    logic [1:0]  imm  [9];
    want = '{ExpFetch, ExpDecode, ExpMemAdr, ExpMemRd, ExpMemWb,
             ExpFetch, ExpDecode, ExpMemAdr, ExpMemWr};
    for (int i = 0; i < 9; i++) begin
      ops[i] = (i < 5) ? 7'b0000011 : 7'b0100011;
      imm[i] = (i < 5) ? 2'b00 : 2'b01;
    end
    for (int c = 0; c < 9; c++) begin
      op = ops[c];
      #1;
      compared++;
      if (obs !== want[c] || ImmSrc !== imm[c]) begin
        mismatched++;
        $display("FAIL b2b_c%0d: got %b imm %b want %b imm %b", c + 1, obs, ImmSrc, want[c],
                 imm[c]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu(7'b0110011, ExpExeR);
    test_alu(7'b0010011, ExpExeI);
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_reset_mid_lw();
    test_back_to_back();
    test_illegal();
    // Machine must be back in FETCH after the illegal-opcode scenario.
    op = 7'b0110011;
    #1;
    compared++;
    if (obs !== ExpFetch) begin
      mismatched++;
      $display("FAIL final_fetch: got %b want %b", obs, ExpFetch);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
